// File: rtl/mod_n_counter.sv
// Synchronous modulo-N up/down counter with clear, clamped load, and optional saturation.
// Outputs tc/wrap let several instances cascade into one clock domain.
module mod_n_counter #(
   parameter int WIDTH    = 7,
   parameter int MODULUS  = 100,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             sat
);

   // MODULUS-1 is formed in 32-bit arithmetic, then narrowed. It always fits, even for MODULUS = 2**WIDTH.
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   logic at_top;
   logic at_bot;
   logic at_end;

   assign at_top = (q == MAX_Q);
   assign at_bot = (q == '0);
   assign at_end = up ? at_top : at_bot;
   assign tc     = en & at_end;

   // NOTE: all state uses non-blocking assignments, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q    <= '0;
         wrap <= 1'b0;
         sat  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            q   <= '0;
            sat <= 1'b0;
         end else if (load) begin
            q   <= (load_val > MAX_Q) ? MAX_Q : load_val;
            sat <= 1'b0;
         end else if (en) begin
            if (at_end && (SATURATE != 0)) begin
               sat <= 1'b1;
            end else begin
               sat  <= 1'b0;
               wrap <= at_end;
               if (up) q <= at_top ? '0 : q + 1'b1;
               else    q <= at_bot ? MAX_Q : q - 1'b1;
            end
         end
      end
   end

endmodule
